// File: rtl/car_ctrl_pkg.sv
// car_ctrl_pkg: shared state encodings, default timing and output decode for the drive controller
package car_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRIVE   = 3'd1,
    S_REFUEL  = 3'd2,
    S_COOL    = 3'd3,
    S_ARRIVED = 3'd4
  } state_t;
  localparam int COOL_CYCLES_DEF = 8;
  function automatic logic [2:0] drive_outs(input logic [2:0] s);
    return {s == S_DRIVE, s == S_COOL, s == S_REFUEL};
  endfunction
endpackage

// File: rtl/cooldown_timer.sv
// cooldown_timer: reloadable down-counter that flags the last cool cycle of a cool-down
module cooldown_timer
  import car_ctrl_pkg::*;
#(
  parameter int COOL_CYCLES = COOL_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic overheat,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(COOL_CYCLES + 1);
  localparam logic [W-1:0] FULL = W'(COOL_CYCLES);
  logic [W-1:0] cool_cnt;
  assign expire = en && !overheat && cool_cnt == W'(1);
  always_ff @(posedge clk)
    if (rst) cool_cnt <= '0;
    else if (load || (en && overheat)) cool_cnt <= FULL;
    else if (en && cool_cnt != '0) cool_cnt <= cool_cnt - W'(1);
endmodule

// File: rtl/car_drive_controller.sv
// car_drive_controller: drive/refuel/cool-down/arrival sequencer with saturating trip and overheat counters
module car_drive_controller
  import car_ctrl_pkg::*;
#(
  parameter int COOL_CYCLES = COOL_CYCLES_DEF,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cpu_overheated,
  input  logic             arrived,
  input  logic             gas_tank_empty,
  input  logic             refuel_done,
  output logic             keep_driving,
  output logic             shut_off_computer,
  output logic             refuel_req,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] trip_count,
  output logic [CNT_W-1:0] overheat_count
);
  state_t state, next;
  logic expire, trip_inc, oh_inc;
  always_comb begin
    next = state;
    case (state)
      S_IDLE:    next = start ? S_DRIVE : S_IDLE;
      S_DRIVE:   next = cpu_overheated ? S_COOL : arrived ? S_ARRIVED : gas_tank_empty ? S_REFUEL : S_DRIVE;
      S_REFUEL:  next = cpu_overheated ? S_COOL : refuel_done ? S_DRIVE : S_REFUEL;
      S_COOL:    next = expire ? S_DRIVE : S_COOL;
      S_ARRIVED: next = !arrived ? S_IDLE : cpu_overheated ? S_COOL : S_ARRIVED;
      default:   next = S_IDLE;
    endcase
  end
  assign trip_inc = state == S_DRIVE && next == S_ARRIVED;
  assign oh_inc   = state != S_COOL && next == S_COOL;
  cooldown_timer #(.COOL_CYCLES(COOL_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .load     (oh_inc),
    .overheat (cpu_overheated),
    .en       (state == S_COOL),
    .expire   (expire)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state          <= S_IDLE;
      trip_count     <= '0;
      overheat_count <= '0;
    end else begin
      state <= next;
      if (trip_inc && trip_count != '1) trip_count <= trip_count + CNT_W'(1);
      if (oh_inc && overheat_count != '1) overheat_count <= overheat_count + CNT_W'(1);
    end
  assign state_o = state;
  assign {keep_driving, shut_off_computer, refuel_req} = drive_outs(state);
endmodule
